hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
- Sequential multiply/divide responder that owns the architectural HI/LO registers of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage over a valid/ready handshake.
- Multiplies with a fixed latency and divides with an iterative radix-2 restoring divider.
- Serves MFHI/MFLO reads, raising a stall to the hazard unit while an operation is in flight.

Parameters:
- MUL_LAT, 4, multiply busy cycles; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit accepts a request this cycle
- req_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 ignored (no effect, no accept)
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- flush  in  1  cancel in-flight operation
- mf_valid  in  1  MFHI/MFLO in execute stage
- mf_sel  in  1  0=HI 1=LO
- hilo  out  32  selected register value
- mf_stall  out  1  read must stall
- busy  out  1  operation in flight

Behaviour:
- Reset (reset_n low, asynchronous): HI=LO=0, state IDLE, all counters/datapath regs 0.
  - Outputs during and after reset: req_ready=1, busy=0, mf_stall=0, hilo=0.
  - Reset mid-operation aborts the operation with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
  - busy = (state != IDLE).
  - req_ready = !busy.
  - Accept = req_valid & req_ready & legal op. While not ready, the initiator holds req_valid, req_op and operands stable.
- IDLE, on accept:
  - MTHI/MTLO: HI (resp. LO) := src_a at the same edge; stay IDLE.
  - MULT/MULTU: compute the 64-bit signed/unsigned product and latch it into a pending register; cnt := MUL_LAT-1; go MUL.
  - DIV/DIVU with src_b==0: HI := src_a, LO := 32'hFFFFFFFF at the same edge; stay IDLE; never busy.
  - DIV/DIVU otherwise:
    - Latch |src_a|, |src_b| (signed) or raw values (unsigned).
    - Latch quotient sign = a[31]^b[31] and remainder sign = a[31] (DIV only).
    - Clear the partial remainder; cnt := 31; go DIV.
- MUL: each cycle cnt--. In the cycle with cnt==0 (completion cycle), at the edge {HI,LO} := pending; go IDLE.
  - Total busy = MUL_LAT cycles.
- DIV: one restoring iteration per cycle:
  - Shift {rem, quo} left 1.
  - If rem >= divisor: subtract and set the quotient LSB.
  - After the cnt==0 iteration, go FIX.
  - 32 cycles in DIV.
- FIX (completion cycle, 1 cycle):
  - LO := quotient negated if its sign bit is set; HI := remainder negated if its sign bit is set.
  - Go IDLE. Total DIV busy = 33 cycles.
- Signed overflow: 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 as a natural result of 32-bit unsigned magnitude arithmetic; no special case.
- flush: while busy, return to IDLE at the next edge with HI/LO unchanged. flush in IDLE has no effect. A flush in the completion cycle wins: no write.
- Read path:
  - hilo = mf_sel ? LO : HI (registered values, combinational mux).
  - mf_stall = mf_valid & busy.
  - Reads in the same cycle as an IDLE accept (MT*, div-by-zero) return the pre-edge value; no bypass.

Optional Feature:
- Macro HILO_BYPASS_EN.
  - Defined: in a completion cycle (last MUL cycle, FIX, or IDLE MTHI/MTLO/div-by-zero accept), hilo returns the value being written to the selected register, and mf_stall deasserts in that cycle. Read latency is one cycle shorter.
  - Undefined: mf_stall stays high through the completion cycle; the result is visible in the following cycle.

Test Plan:
- MULT a=0xFFFFFFFE, b=3, MUL_LAT=4 -> busy 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. A second req_valid held during busy is accepted only when req_ready returns.
- DIV a=-7 (0xFFFFFFF9), b=2, mf_valid=1 with mf_sel=1 throughout -> busy and mf_stall high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF, hilo=0xFFFFFFFD.
- DIVU a=0x1234, b=0 -> same-edge HI=0x1234, LO=0xFFFFFFFF, busy never asserted. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA5555, then DIV 100/7 with flush at DIV cycle 10 -> HI remains 0xAAAA5555, busy drops the next cycle. Repeat with reset_n low mid-DIV -> HI=LO=0 immediately.
- With HILO_BYPASS_EN: MTLO 0x12345678 with mf_valid/mf_sel=1 in the same cycle -> hilo=0x12345678 that cycle. Without it -> old LO that cycle, new value the next cycle.

Source files
------------

// File: rtl/hilo_mdu_if.sv
// Request channel from the execute stage to the HI/LO multiply/divide unit.
// The master presents an op and operands. The slave (hilo_mdu) returns ready.
interface hilo_mdu_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;

    modport master (output req_valid, output req_op, output src_a, output src_b, input req_ready);
    modport slave  (input req_valid, input req_op, input src_a, input src_b, output req_ready);
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO owner for the MIPS core: fixed-latency multiply, radix-2 restoring divide, MFHI/MFLO read path.
// Optional macro HILO_BYPASS_EN forwards the value being written to the read port in a completion cycle.
module hilo_mdu #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    hilo_mdu_if.slave   req,
    input  logic        flush,
    input  logic        mf_valid,
    input  logic        mf_sel,
    output logic [31:0] hilo,
    output logic        mf_stall,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] pend;
    logic [31:0] hi, lo;
    logic [31:0] rem, quo, dvs;
    logic        q_neg, r_neg;

    logic        accept, is_mul, is_div, signed_op, div_zero;
    logic [63:0] ext_a, ext_b, product;
    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_sh, rem_diff;
    logic        quo_bit;
    logic [31:0] rem_step;
    logic        done;
    logic        hi_we, lo_we;
    logic [31:0] hi_nxt, lo_nxt;

    // Request decode and operand conditioning.
    always_comb begin
        busy          = (state != S_IDLE);
        req.req_ready = !busy;
        accept        = req.req_valid && req.req_ready && (req.req_op <= OP_MTLO);
        is_mul        = (req.req_op == OP_MULT) || (req.req_op == OP_MULTU);
        is_div        = (req.req_op == OP_DIV)  || (req.req_op == OP_DIVU);
        signed_op     = (req.req_op == OP_MULT) || (req.req_op == OP_DIV);
        div_zero      = is_div && (req.src_b == 32'd0);
        ext_a         = signed_op ? {{32{req.src_a[31]}}, req.src_a} : {32'd0, req.src_a};
        ext_b         = signed_op ? {{32{req.src_b[31]}}, req.src_b} : {32'd0, req.src_b};
        // Low 64 bits of the widened product are correct for both signed and unsigned.
        product       = ext_a * ext_b;
        mag_a         = (signed_op && req.src_a[31]) ? (~req.src_a + 32'd1) : req.src_a;
        mag_b         = (signed_op && req.src_b[31]) ? (~req.src_b + 32'd1) : req.src_b;
    end

    // One restoring step: the 33-bit difference's top bit is the borrow.
    always_comb begin
        rem_sh   = {rem, quo[31]};
        rem_diff = rem_sh - {1'b0, dvs};
        quo_bit  = !rem_diff[32];
        rem_step = quo_bit ? rem_diff[31:0] : rem_sh[31:0];
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_mul)
                    state_nxt = S_MUL;
                else if (accept && is_div && !div_zero)
                    state_nxt = S_DIV;
            end
            S_MUL: begin
                if (flush)
                    state_nxt = S_IDLE;
                else if (cnt == 5'd0) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end
            end
            S_DIV: begin
                if (flush)
                    state_nxt = S_IDLE;
                else if (cnt == 5'd0)
                    state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                done      = !flush;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // HI/LO write selection. A flush in a completion cycle clears done, suppressing the write.
    always_comb begin
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        hi_nxt = hi;
        lo_nxt = lo;
        if (state == S_IDLE && accept) begin
            if (req.req_op == OP_MTHI) begin
                hi_we  = 1'b1;
                hi_nxt = req.src_a;
            end else if (req.req_op == OP_MTLO) begin
                lo_we  = 1'b1;
                lo_nxt = req.src_a;
            end else if (div_zero) begin
                hi_we  = 1'b1;
                lo_we  = 1'b1;
                hi_nxt = req.src_a;
                lo_nxt = 32'hFFFF_FFFF;
            end
        end else if (done && state == S_MUL) begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_nxt = pend[63:32];
            lo_nxt = pend[31:0];
        end else if (done && state == S_FIX) begin
            hi_we  = 1'b1;
            lo_we  = 1'b1;
            hi_nxt = r_neg ? (~rem + 32'd1) : rem;
            lo_nxt = q_neg ? (~quo + 32'd1) : quo;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (hi_we) hi <= hi_nxt;
            if (lo_we) lo <= lo_nxt;
        end
    end

    // NOTE: the datapath registers are reset as well, so a mid-operation reset leaves no stale operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= 5'd0;
            pend  <= 64'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            dvs   <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        pend <= product;
                        cnt  <= 5'(MUL_LAT - 1);
                    end else if (accept && is_div && !div_zero) begin
                        quo   <= mag_a;
                        dvs   <= mag_b;
                        rem   <= 32'd0;
                        cnt   <= 5'd31;
                        q_neg <= (req.req_op == OP_DIV) && (req.src_a[31] ^ req.src_b[31]);
                        r_neg <= (req.req_op == OP_DIV) && req.src_a[31];
                    end
                end
                S_MUL: begin
                    if (!flush && cnt != 5'd0)
                        cnt <= cnt - 5'd1;
                end
                S_DIV: begin
                    if (!flush) begin
                        rem <= rem_step;
                        quo <= {quo[30:0], quo_bit};
                        if (cnt != 5'd0)
                            cnt <= cnt - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HILO_BYPASS_EN
    // hi_nxt/lo_nxt equal the registered values unless a write lands at this edge.
    always_comb begin
        hilo     = mf_sel ? lo_nxt : hi_nxt;
        mf_stall = mf_valid && busy && !done;
    end
`else
    always_comb begin
        hilo     = mf_sel ? lo : hi;
        mf_stall = mf_valid && busy;
    end
`endif

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed testbench for hilo_mdu: multiply/divide results, latencies, flush, reset and the read path.
module tb_hilo_mdu;
    localparam int MUL_LAT = 4;
`ifdef HILO_BYPASS_EN
    localparam int DIV_STALL = 32;
`else
    localparam int DIV_STALL = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        mf_valid = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] hilo;
    logic        mf_stall;
    logic        busy;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n;

    hilo_mdu_if req ();

    hilo_mdu #(.MUL_LAT(MUL_LAT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .flush    (flush),
        .mf_valid (mf_valid),
        .mf_sel   (mf_sel),
        .hilo     (hilo),
        .mf_stall (mf_stall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_regs(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
        mf_sel = 1'b0;
        #1 check({tag, "_hi"}, hilo, e_hi);
        mf_sel = 1'b1;
        #1 check({tag, "_lo"}, hilo, e_lo);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        req.req_valid = 1'b1;
        req.req_op    = op;
        req.src_a     = a;
        req.src_b     = b;
        w = 0;
        while (!req.req_ready && w < 100) begin
            step();
            w++;
        end
        step();
        req.req_valid = 1'b0;
    endtask

    task automatic run_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req.req_valid = 1'b0;
        req.req_op    = 3'd0;
        req.src_a     = 32'd0;
        req.src_b     = 32'd0;

        // Reset values, with a read pending.
        mf_valid = 1'b1;
        #3;
        check("rst_ready", 32'(req.req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(mf_stall), 32'd0);
        check("rst_hilo", hilo, 32'd0);
        mf_valid = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // MULT -2 * 3.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy", 32'(busy), 32'd1);
        run_busy(n);
        check("mult_lat", n, MUL_LAT);
        read_regs("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // MULTU max*max, then an MTLO held while the unit is busy.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req.req_valid = 1'b1;
        req.req_op    = 3'd5;
        req.src_a     = 32'h0000_5555;
        #1 check("held_not_ready", 32'(req.req_ready), 32'd0);
        n = 0;
        while (!req.req_ready && n < 100) begin
            n++;
            step();
        end
        check("held_wait", n, MUL_LAT);
        mf_sel = 1'b0;
        #1 check("multu_hi", hilo, 32'hFFFF_FFFE);
        step();
        req.req_valid = 1'b0;
        read_regs("held_mtlo", 32'hFFFF_FFFE, 32'h0000_5555);

        // DIV -7 / 2 with an MFLO waiting throughout.
        mf_valid = 1'b1;
        mf_sel   = 1'b1;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        n = 0;
        while (mf_stall && n < 200) begin
            n++;
            step();
        end
        check("div_stall_cycles", n, DIV_STALL);
        check("div_hilo", hilo, 32'hFFFF_FFFD);
        mf_valid = 1'b0;
        step();
        check("div_idle", 32'(busy), 32'd0);
        read_regs("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIVU by zero completes at the accept edge.
        req.req_valid = 1'b1;
        req.req_op    = 3'd3;
        req.src_a     = 32'h0000_1234;
        req.src_b     = 32'd0;
        #1 check("dz_busy_pre", 32'(busy), 32'd0);
        step();
        req.req_valid = 1'b0;
        check("dz_busy_post", 32'(busy), 32'd0);
        read_regs("dz", 32'h0000_1234, 32'hFFFF_FFFF);

        // Signed overflow case.
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy(n);
        check("ovf_lat", n, 33);
        read_regs("ovf", 32'd0, 32'h8000_0000);

        // MTHI then DIV 100/7 flushed in its 10th cycle.
        issue(3'd4, 32'hAAAA_5555, 32'd0);
        read_regs("mthi", 32'hAAAA_5555, 32'h8000_0000);
        issue(3'd2, 32'd100, 32'd7);
        repeat (9) step();
        check("flush_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_post", 32'(busy), 32'd0);
        read_regs("flush", 32'hAAAA_5555, 32'h8000_0000);

        // The same divide run to completion.
        issue(3'd2, 32'd100, 32'd7);
        run_busy(n);
        read_regs("div100", 32'd2, 32'd14);

        // Asynchronous reset in the middle of a divide.
        issue(3'd3, 32'd100, 32'd7);
        repeat (5) step();
        reset_n = 1'b0;
        #1 check("mid_rst_busy", 32'(busy), 32'd0);
        read_regs("mid_rst", 32'd0, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // MTLO with a same-cycle MFLO.
        mf_valid      = 1'b1;
        mf_sel        = 1'b1;
        req.req_valid = 1'b1;
        req.req_op    = 3'd5;
        req.src_a     = 32'h1234_5678;
`ifdef HILO_BYPASS_EN
        #1 check("mtlo_same", hilo, 32'h1234_5678);
`else
        #1 check("mtlo_same", hilo, 32'd0);
`endif
        step();
        req.req_valid = 1'b0;
        check("mtlo_next", hilo, 32'h1234_5678);
        mf_valid = 1'b0;

        // Reserved ops 6 and 7 are ignored.
        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        check("op6_busy", 32'(busy), 32'd0);
        issue(3'd7, 32'hDEAD_BEEF, 32'd0);
        read_regs("op7", 32'd0, 32'h1234_5678);

        // Flush while idle, then a flush in the multiply completion cycle.
        flush = 1'b1;
        step();
        flush = 1'b0;
        read_regs("idle_flush", 32'd0, 32'h1234_5678);
        issue(3'd0, 32'd3, 32'd5);
        repeat (MUL_LAT - 1) step();
        check("mflush_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("mflush_idle", 32'(busy), 32'd0);
        read_regs("mflush", 32'd0, 32'h1234_5678);
        issue(3'd0, 32'd3, 32'd5);
        run_busy(n);
        read_regs("mult15", 32'd0, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
